// File: rtl/cnt_sched_ctrl.sv
// cnt_sched_ctrl: round-robin scheduler sharing one run counter among NREQ requesters; CNT_SCHED_PAUSE_EN adds the pause input.
module cnt_sched_ctrl #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDXW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len_i,
`ifdef CNT_SCHED_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [NREQ-1:0]       grant,
    output logic [IDXW-1:0]       owner,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done,
    output logic                  abort
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [IDXW-1:0]  ptr, ptr_n, owner_n, win, nxt;
    logic [NREQ-1:0]  grant_n, done_n;
    logic [WIDTH-1:0] count_n, len_q, len_n, sel_len;
    logic             busy_n, abort_n, found, hold;
`ifdef CNT_SCHED_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif
    assign nxt = (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;
    // first pass finds the lowest requester at or above ptr, second wraps to the lowest overall
    always_comb begin
        found   = 1'b0;
        win     = '0;
        sel_len = '0;
        for (int k = 0; k < NREQ; k++)
            if (!found && req[k] && IDXW'(k) >= ptr) begin
                win   = IDXW'(k);
                found = 1'b1;
            end
        for (int k = 0; k < NREQ; k++)
            if (!found && req[k]) begin
                win   = IDXW'(k);
                found = 1'b1;
            end
        for (int k = 0; k < NREQ; k++)
            if (IDXW'(k) == win) sel_len = len_i[k*WIDTH +: WIDTH];
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        busy_n  = busy;
        count_n = count;
        len_n   = len_q;
        ptr_n   = ptr;
        done_n  = '0;
        abort_n = 1'b0;
        case (state)
            IDLE:
                if (|req) begin
                    state_n = RUN;
                    grant_n = NREQ'(1) << win;
                    owner_n = win;
                    len_n   = sel_len;
                    count_n = '0;
                    busy_n  = 1'b1;
                end
            RUN:
                if (!req[owner]) begin
                    state_n = IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    count_n = '0;
                    abort_n = 1'b1;
                    ptr_n   = nxt;
                end else if (count == len_q) begin
                    state_n = DONE;
                    grant_n = '0;
                    done_n  = NREQ'(1) << owner;
                    ptr_n   = nxt;
                end else if (!hold) begin
                    count_n = count + 1'b1;
                end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                count_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            busy  <= 1'b0;
            count <= '0;
            len_q <= '0;
            ptr   <= '0;
            done  <= '0;
            abort <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            owner <= owner_n;
            busy  <= busy_n;
            count <= count_n;
            len_q <= len_n;
            ptr   <= ptr_n;
            done  <= done_n;
            abort <= abort_n;
        end
    end
endmodule

// File: tb/tb_cnt_sched_ctrl.sv
// tb_cnt_sched_ctrl: directed vector table plus hand sequences for cnt_sched_ctrl.
module tb_cnt_sched_ctrl;
    logic        clk = 1'b0, rst = 1'b0, pause = 1'b0, started = 1'b0;
    logic [3:0]  req = '0, grant, count, done;
    logic [15:0] len_i = '0;
    logic [1:0]  owner;
    logic        busy, abort;
    int          checks = 0, errors = 0;
    typedef struct {
        logic rst; logic [3:0] req; logic [15:0] len;
        logic [3:0] grant; logic [1:0] owner; logic busy; logic [3:0] count; logic [3:0] done; logic abort;
    } vec_t;
    vec_t tbl[$];
    cnt_sched_ctrl #(.NREQ(4), .WIDTH(4), .IDXW(2)) dut (
        .clk(clk), .rst(rst), .req(req), .len_i(len_i),
`ifdef CNT_SCHED_PAUSE_EN
        .pause(pause),
`endif
        .grant(grant), .owner(owner), .busy(busy), .count(count), .done(done), .abort(abort)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic add(input logic r, input logic [3:0] q, input logic [15:0] l, input logic [3:0] g,
                       input logic [1:0] o, input logic b, input logic [3:0] c, input logic [3:0] d, input logic a);
        tbl.push_back('{r, q, l, g, o, b, c, d, a});
    endtask
    task automatic chk_all(input string n, input logic [3:0] g, input logic [1:0] o, input logic b,
                           input logic [3:0] c, input logic [3:0] d, input logic a);
        chk({n, " grant"}, 32'(grant), 32'(g));
        chk({n, " owner"}, 32'(owner), 32'(o));
        chk({n, " busy"},  32'(busy),  32'(b));
        chk({n, " count"}, 32'(count), 32'(c));
        chk({n, " done"},  32'(done),  32'(d));
        chk({n, " abort"}, 32'(abort), 32'(a));
    endtask
    always @(negedge clk)
        if (started) begin
            chk("inv grant onehot0", 32'($onehot0(grant)), 32'd1);
            chk("inv done onehot0", 32'($onehot0(done)), 32'd1);
            chk("inv done+abort", 32'(|done && abort), 32'd0);
            chk("inv grant only in run", 32'(|grant && (!busy || |done || abort)), 32'd0);
        end
    initial begin
        // single request, requester 1, len 3
        add(0, 4'b0000, 16'h0030, 4'b0000, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0000, 16'h0030, 4'b0000, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0010, 16'h0030, 4'b0010, 1, 1, 0, 4'b0000, 0);
        add(1, 4'b0010, 16'h0030, 4'b0010, 1, 1, 1, 4'b0000, 0);
        add(1, 4'b0010, 16'h0030, 4'b0010, 1, 1, 2, 4'b0000, 0);
        add(1, 4'b0010, 16'h0030, 4'b0010, 1, 1, 3, 4'b0000, 0);
        add(1, 4'b0010, 16'h0030, 4'b0000, 1, 1, 3, 4'b0010, 0);
        add(1, 4'b0000, 16'h0030, 4'b0000, 1, 0, 0, 4'b0000, 0);
        add(1, 4'b0000, 16'h0030, 4'b0000, 1, 0, 0, 4'b0000, 0);
        // round robin, all requesting, all len 1
        add(0, 4'b0000, 16'h1111, 4'b0000, 0, 0, 0, 4'b0000, 0);
        for (int k = 0; k < 4; k++) begin
            add(1, 4'b1111, 16'h1111, 4'(1 << k), 2'(k), 1, 0, 4'b0000, 0);
            add(1, 4'b1111, 16'h1111, 4'(1 << k), 2'(k), 1, 1, 4'b0000, 0);
            add(1, 4'b1111, 16'h1111, 4'b0000,    2'(k), 1, 1, 4'(1 << k), 0);
            add(1, 4'b1111, 16'h1111, 4'b0000,    2'(k), 0, 0, 4'b0000, 0);
        end
        add(1, 4'b1111, 16'h1111, 4'b0001, 0, 1, 0, 4'b0000, 0);
        add(1, 4'b1111, 16'h1111, 4'b0001, 0, 1, 1, 4'b0000, 0);
        add(0, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 4'b0000, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; len_i = tbl[i].len;
            tick();
            started = 1'b1;
            chk_all($sformatf("v%0d", i), tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].count, tbl[i].done, tbl[i].abort);
        end
        // zero length: one RUN cycle then done
        rst = 1; req = 4'b0001; len_i = 16'h0000;
        tick(); chk_all("zero grant", 4'b0001, 0, 1, 0, 4'b0000, 0);
        tick(); chk_all("zero done", 4'b0000, 0, 1, 0, 4'b0001, 0);
        req = 0;
        tick(); chk_all("zero idle", 4'b0000, 0, 0, 0, 4'b0000, 0);
        // max length: 16 RUN cycles, no wrap
        rst = 0; tick(); rst = 1; req = 4'b0001; len_i = 16'h000F;
        tick(); chk_all("max grant", 4'b0001, 0, 1, 0, 4'b0000, 0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("max count %0d", i), 32'(count), 32'(i));
            chk($sformatf("max grant %0d", i), 32'(grant), 32'b0001);
        end
        tick(); chk_all("max done", 4'b0000, 0, 1, 15, 4'b0001, 0);
        req = 0;
        tick(); chk_all("max idle", 4'b0000, 0, 0, 0, 4'b0000, 0);
        // abort: owner 2 drops at count 4; ptr moves to 3
        rst = 0; tick(); rst = 1; req = 4'b0100; len_i = 16'h0900;
        tick(); chk_all("ab grant", 4'b0100, 2, 1, 0, 4'b0000, 0);
        repeat (4) tick();
        chk("ab count4", 32'(count), 32'd4);
        req = 4'b1011; len_i = 16'h9900;
        tick(); chk_all("ab pulse", 4'b0000, 2, 0, 0, 4'b0000, 1);
        tick(); chk_all("ab next", 4'b1000, 3, 1, 0, 4'b0000, 0);
        // len change during run is ignored; reset mid-run clears ptr
        len_i = 16'h1100;
        repeat (5) tick();
        chk("latch count5", 32'(count), 32'd5);
        chk("latch grant", 32'(grant), 32'b1000);
        rst = 0;
        tick(); chk_all("mid rst", 4'b0000, 0, 0, 0, 4'b0000, 0);
        rst = 1; req = 4'b1001;
        tick(); chk_all("post rst", 4'b0001, 0, 1, 0, 4'b0000, 0);
`ifdef CNT_SCHED_PAUSE_EN
        rst = 0; tick(); rst = 1; req = 4'b0001; len_i = 16'h0004;
        tick(); chk("pz c0", 32'(count), 32'd0);
        tick(); chk("pz c1", 32'(count), 32'd1);
        tick(); chk("pz c2", 32'(count), 32'd2);
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("pz hold %0d", i), 32'(count), 32'd2);
        end
        pause = 0;
        tick(); chk("pz c3", 32'(count), 32'd3);
        tick(); chk("pz c4", 32'(count), 32'd4);
        chk("pz grant", 32'(grant), 32'b0001);
        tick(); chk_all("pz done", 4'b0000, 0, 1, 4, 4'b0001, 0);
        req = 0;
        tick(); chk("pz done once", 32'(done), 32'd0);
`endif
        rst = 0; tick();
        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnt_sched_ctrl.md
Name: cnt_sched_ctrl

Overview:
- Scheduler that time-shares one WIDTH-bit run counter between NREQ requesters.
- Each requester asks for a count run of a programmed length. The block grants requesters round-robin, sequences the counter from 0 up to the latched length, then pulses done to the owner.
- Sits in front of the counter datapath and serialises all count jobs onto it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, counter and length width in bits.
- IDXW, 2, width of the owner index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- req  input  NREQ  per-requester level request; held high until done or abort.
- len_i  input  NREQ*WIDTH  per-requester terminal count; slice k = len_i[k*WIDTH +: WIDTH].
- pause  input  1  freeze count while in RUN (present only with the optional feature).
- grant  output  NREQ  one-hot current owner; all zero when not in RUN.
- owner  output  IDXW  index of the current or last owner.
- busy  output  1  high in RUN and DONE.
- count  output  WIDTH  live counter value.
- done  output  NREQ  one-cycle completion pulse to the owner.
- abort  output  1  one-cycle pulse when the owner drops req mid-run.

Behaviour:
- Reset (rst==0 at a clock edge), regardless of state:
  - state=IDLE, grant=0, owner=0, busy=0, count=0, done=0, abort=0.
  - Round-robin pointer ptr=0.
- States: IDLE, RUN, DONE. Outputs are registered; state encoding is free.
- IDLE:
  - If req!=0, choose the first requester with req high, searching ptr, ptr+1, ... mod NREQ.
  - On the next edge: state=RUN, grant=onehot(winner), owner=winner, len_q=len_i slice of the winner, count=0, busy=1.
  - If req==0, remain in IDLE with all outputs at their idle values.
- RUN, evaluated in this priority order each edge:
  1. req[owner]==0: abort. state=IDLE, grant=0, busy=0, count=0, abort=1 for one cycle, no done; ptr=owner+1 mod NREQ.
  2. count==len_q: state=DONE, grant=0, done[owner]=1 for one cycle, count holds; ptr=owner+1 mod NREQ.
  3. Pause active (feature enabled): hold count.
  4. Otherwise count=count+1.
  - A run occupies len_q+1 RUN cycles; len_q=0 gives exactly one RUN cycle.
  - Count never wraps: terminal detection happens before any increment, so len_q=2^WIDTH-1 completes at all-ones.
- DONE:
  - Lasts one cycle, then state=IDLE, busy=0, count=0.
  - Requester turnaround: a new grant can appear no earlier than 2 edges after DONE is entered.
- Length and request changes:
  - len_i changes during RUN are ignored because len_q is latched at grant.
  - Other requesters asserting req during RUN wait; there is no preemption.
- Fairness: after any completion or abort, the finished owner has lowest priority, so each waiting requester is granted within NREQ-1 runs.
- Invariants (assertion checks):
  - grant is one-hot or zero.
  - done is one-hot or zero.
  - done and abort are never high together.
  - grant is nonzero only in RUN.

Optional Feature:
- Macro: CNT_SCHED_PAUSE_EN.
- Defined:
  - pause port exists.
  - pause==1 in RUN freezes count; the terminal check still runs, so a paused run sitting at len_q completes.
  - Abort still has priority over pause.
- Undefined:
  - pause port is absent; the count advances every RUN cycle.
  - All other behaviour is identical.

Test Plan:
- Reset then single request: rst=0 for 2 cycles, then rst=1, req=0010, len1=3 -> grant=0010 one edge after req; count 0,1,2,3 over 4 cycles; then done=0010 for exactly 1 cycle with grant=0; busy low 1 cycle later.
- Round-robin contention: req=1111 held, all len=1 -> grant order 0001, 0010, 0100, 1000, 0001; each grant lasts 2 cycles; done pulses follow the same order.
- Zero and max length: len=0 -> one RUN cycle with count=0, then done. len=15 (WIDTH=4) -> count reaches 15, no wrap to 0 before done, 16 RUN cycles.
- Abort mid-run: owner 2, len=9, drop req[2] when count=4 -> abort=1 one cycle, done stays 0, count=0. Next grant goes to requester 3 if it is requesting, otherwise to 0.
- Reset mid-operation: rst=0 during RUN at count=5 -> next edge all outputs zero, state IDLE. With req=1001 after release, the first grant is 0001 (ptr=0).
- Pause (CNT_SCHED_PAUSE_EN defined): len=4, pause=1 for 3 cycles at count=2 -> count holds at 2 for 3 cycles; the run takes 8 RUN cycles in total; done is still a single pulse.
